// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive/transmit types and frame geometry defaults.
// Holds the receiver FSM encoding and a parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'b000,
        RX_START  = 3'b001,
        RX_DATA   = 3'b010,
        RX_PARITY = 3'b011,
        RX_STOP   = 3'b100
    } rx_state_t;

    // Parity bit a transmitter attaches to a frame of up to 9 data bits.
    // Unused upper bits must be zero; odd=1 selects odd parity.
    function automatic logic parity_of(
        input logic [8:0] bits,
        input logic       odd
    );
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: two-flop synchronizer for a single asynchronous input.
// Ports: clock, reset (sync, active-high), d (async in), q (synchronized out).
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receive stage with valid/ready byte output.
// Ports: clock, reset (sync, active-high), rxclk_en (oversample tick), rx
// (async serial line), rx_data/rx_valid/rx_ready (byte handshake), err_clr,
// sticky frame_err/parity_err/overrun flags, estado (FSM state for debug).
// Optional feature: define UART_RX_PARITY_EN to add a parity bit per frame
// (PARITY_ODD selects odd parity); otherwise parity_err is tied to 0.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxclk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [2:0]           estado
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 ||
            (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
            $error("uart_receiver: unsupported parameter set");
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = RX_PARITY;
    localparam logic      PAR_ODD    = 1'(PARITY_ODD);
`else
    localparam rx_state_t AFTER_DATA = RX_STOP;
`endif

    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 rx_s;
    logic                 prev_rx;
    logic                 deliver;
    logic                 frame_set;
    logic                 load;
    logic                 ovr_set;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
    logic parity_set;
    logic parity_q;
`else
    logic par_bad;
    assign par_bad = 1'b0;
`endif

    bit_synchronizer #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign estado = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            prev_rx <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            // Edge history advances only on ticks, so a line that was
            // sampled low at the stop bit cannot look like a new edge.
            if (rxclk_en) begin
                prev_rx <= rx_s;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        deliver   = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        parity_set = 1'b0;
`endif
        if (rxclk_en) begin
            unique case (state)
                RX_IDLE: begin
                    if (prev_rx && !rx_s) begin
                        state_n = RX_START;
                        cnt_n   = '0;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_MID) begin
                        cnt_n = '0;
                        if (!rx_s) begin
                            state_n = RX_DATA;
                            idx_n   = '0;
`ifdef UART_RX_PARITY_EN
                            par_bad_n = 1'b0;
`endif
                        end else begin
                            state_n = RX_IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        idx_n   = idx + 1'b1;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            state_n = AFTER_DATA;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = RX_STOP;
                        if (rx_s != parity_of(9'(shreg), PAR_ODD)) begin
                            parity_set = 1'b1;
                            par_bad_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = RX_IDLE;
                        if (!rx_s) begin
                            frame_set = 1'b1;
                        end else if (!par_bad) begin
                            deliver = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = RX_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // A new byte may replace the held one only if the consumer is taking
    // the held one in this very cycle; otherwise the new byte is lost.
    assign load    = deliver && (!rx_valid || rx_ready);
    assign ovr_set = deliver && rx_valid && !rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err <= frame_set | (frame_err & ~err_clr);
            overrun   <= ovr_set | (overrun & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            par_bad  <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            par_bad  <= par_bad_n;
            parity_q <= parity_set | (parity_q & ~err_clr);
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frames against a frame-level
// model of byte delivery, overrun and sticky error behaviour.
module tb_uart_receiver;

    localparam int   BIT_CLKS = 16;
    localparam logic PAR_ODD  = 1'b0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxclk_en = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [2:0] estado;

    uart_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .PARITY_ODD (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rxclk_en   (rxclk_en),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .err_clr    (err_clr),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .estado     (estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor: bytes taken by the consumer and rx_valid rising edges.
    logic [7:0] acc_q[$];
    int         rises = 0;
    int         last_rise_cyc = 0;
    logic       valid_d = 1'b0;

    always @(negedge clock) begin
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        if (rx_valid && !valid_d) begin
            rises++;
            last_rise_cyc = cyc;
        end
        valid_d = rx_valid;
    end

    // Frame-level model state.
    logic [7:0] exp_q[$];
    int         acc_rd = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_frame = 1'b0;
    logic       m_par = 1'b0;
    logic       m_ovr = 1'b0;
    int         m_rises = 0;
    int         edge_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(1'b1);
    endtask

    // One frame as seen by a consumer whose rx_ready is held throughout.
    task automatic mdl_frame(input logic [7:0] d, input logic sb,
                             input logic pok);
        if (rx_ready && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
        if (!pok) m_par = 1'b1;
        if (!sb) begin
            m_frame = 1'b1;
        end else if (pok) begin
            if (!m_valid) begin
                m_data = d;
                m_rises++;
                if (rx_ready) exp_q.push_back(d);
                else m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sb,
                             input logic pok);
        edge_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ PAR_ODD ^ !pok);
`endif
        drive_bit(sb);
        mdl_frame(d, sb, pok);
    endtask

    task automatic verify(input string tag);
        chk({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_frame));
        chk({tag, "_perr"}, 32'(parity_err), 32'(m_par));
        chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        chk({tag, "_state"}, 32'(estado), 32'd0);
        chk({tag, "_rises"}, 32'(rises), 32'(m_rises));
        chk({tag, "_nacc"}, 32'(acc_q.size()), 32'(exp_q.size()));
        while (acc_rd < acc_q.size() && acc_rd < exp_q.size()) begin
            chk({tag, "_acc"}, 32'(acc_q[acc_rd]), 32'(exp_q[acc_rd]));
            acc_rd++;
        end
    endtask

    task automatic txrx(input logic [7:0] d, input logic sb,
                        input logic pok, input string tag);
        send_byte(d, sb, pok);
        idle(2);
        verify(tag);
    endtask

    task automatic clr_errs();
        err_clr = 1'b1;
        @(posedge clock);
        #1;
        err_clr = 1'b0;
        m_frame = 1'b0;
        m_par = 1'b0;
        m_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       sb;
        logic       pok;
        int         lat;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", 32'(estado), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        idle(1);

        // Basic frame with a ready consumer.
        rx_ready = 1'b1;
        txrx(8'hA5, 1'b1, 1'b1, "t1");
        lat = last_rise_cyc - edge_cyc;
        chk("t1_latency_ok", 32'(lat >= 152 && lat <= 158), 32'd1);

        // Short low glitch is rejected in START.
        rx = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        rx = 1'b1;
        chk("t2_start", 32'(estado), 32'd1);
        repeat (30) @(posedge clock);
        #1;
        verify("t2");

        // Bad stop, then a break held low, then recovery.
        send_byte(8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive_bit(1'b0);
        verify("t3_break");
        idle(2);
        txrx(8'h55, 1'b1, 1'b1, "t3_55");
        clr_errs();
        verify("t3_clr");

        // Overrun with a stalled consumer.
        rx_ready = 1'b0;
        txrx(8'h11, 1'b1, 1'b1, "t4_11");
        txrx(8'h22, 1'b1, 1'b1, "t4_22");
        rx_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(m_data);
        m_valid = 1'b0;
        verify("t4_drain");
        clr_errs();

        // Reset in the middle of data bit 3 with a byte pending.
        rx_ready = 1'b0;
        txrx(8'h42, 1'b1, 1'b1, "t5_pend");
        d = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx = d[3];
        repeat (8) @(posedge clock);
        #1;
        chk("t5_in_data", 32'(estado), 32'd2);
        rx = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_valid = 1'b0;
        m_data = 8'h00;
        m_frame = 1'b0;
        m_par = 1'b0;
        m_ovr = 1'b0;
        chk("t5_rst_state", 32'(estado), 32'd0);
        chk("t5_rst_valid", 32'(rx_valid), 32'd0);
        idle(2);
        rx_ready = 1'b1;
        txrx(8'h7E, 1'b1, 1'b1, "t5_7e");

`ifdef UART_RX_PARITY_EN
        txrx(8'h01, 1'b1, 1'b1, "t6_par_ok");
        txrx(8'h01, 1'b1, 1'b0, "t6_par_bad");
        clr_errs();
`endif

        // Randomized frames, consumer stalls and flag clears.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            pok = ($urandom_range(0, 5) != 0);
`else
            pok = 1'b1;
`endif
            rx_ready = ($urandom_range(0, 2) != 0);
            txrx(d, sb, pok, "rnd");
            if ($urandom_range(0, 3) == 0) begin
                clr_errs();
                verify("rnd_clr");
            end
        end

        rx_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        if (m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
        verify("final");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
